// File: rtl/gf8_mul_rr_sched.sv
// gf8_mul_rr_sched: round-robin arbiter sharing one GF(2^8) multiplier among
// NREQ valid/ready requesters. One registered result slot with backpressure;
// the winner's product and index are presented one cycle after acceptance.
module gf8_mul_rr_sched #(
    parameter int         NREQ = 4,
    parameter logic [7:0] POLY = 8'h1B,
    parameter int         IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_y,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       acc_cnt,
    output logic              busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_r;
    logic [IDW-1:0]      ptr_r;
    logic [IDW-1:0]      grant_s;
    logic [IDW:0]        sum_s;
    logic [IDW:0]        next_sum_s;
    logic [IDW-1:0]      next_ptr_s;
    logic                found_s;
    logic                can_accept_s;
    logic                accept_s;
    logic [2*NREQ-1:0]   dbl_s;
    logic [NREQ-1:0]     rot_s;
    logic [7:0]          win_a_s;
    logic [7:0]          win_b_s;

    // Carry-less 8x8 multiply followed by top-down reduction modulo x^8+POLY.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'h0000;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ (15'(a) << i);
            end else begin
                p = p;
            end
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) begin
                p = p ^ ((15'(POLY) << (k - 8)) | (15'h0001 << k));
            end else begin
                p = p;
            end
        end
        return p[7:0];
    endfunction

    // Rotate the request vector so index 0 is the pointer, pick the first set bit.
    always_comb begin
        dbl_s   = {req_valid, req_valid} >> ptr_r;
        rot_s   = dbl_s[NREQ-1:0];
        found_s = 1'b0;
        sum_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_s && rot_s[i]) begin
                found_s = 1'b1;
                sum_s   = {1'b0, ptr_r} + (IDW+1)'(i);
            end else begin
                found_s = found_s;
            end
        end
        if (sum_s >= (IDW+1)'(NREQ)) begin
            sum_s = sum_s - (IDW+1)'(NREQ);
        end else begin
            sum_s = sum_s;
        end
        grant_s = sum_s[IDW-1:0];
    end

    // Pointer advance past the winner, wrapping modulo NREQ.
    always_comb begin
        next_sum_s = {1'b0, grant_s} + {{IDW{1'b0}}, 1'b1};
        if (next_sum_s >= (IDW+1)'(NREQ)) begin
            next_sum_s = '0;
        end else begin
            next_sum_s = next_sum_s;
        end
        next_ptr_s = next_sum_s[IDW-1:0];
    end

    // Handshake: only the winner sees ready, and only when the slot can take data.
    always_comb begin
        can_accept_s = (state_r == EMPTY) || rsp_ready;
        accept_s     = found_s && can_accept_s && !rst;
        req_ready    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (accept_s && (grant_s == IDW'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Operand mux selecting the winner's A/B pair.
    always_comb begin
        win_a_s = 8'h00;
        win_b_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s == IDW'(i)) begin
                win_a_s = req_a[i*8 +: 8];
                win_b_s = req_b[i*8 +: 8];
            end else begin
                win_a_s = win_a_s;
                win_b_s = win_b_s;
            end
        end
    end

    // Output slot FSM plus result, pointer and accept counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
            rsp_y   <= 8'h00;
            rsp_id  <= '0;
            acc_cnt <= 16'h0000;
            ptr_r   <= '0;
        end else begin
            case (state_r)
                EMPTY:   state_r <= accept_s ? FULL : EMPTY;
                FULL:    state_r <= (rsp_ready && !accept_s) ? EMPTY : FULL;
                default: state_r <= EMPTY;
            endcase
            if (accept_s) begin
                rsp_y   <= gf_mul(win_a_s, win_b_s);
                rsp_id  <= grant_s;
                ptr_r   <= next_ptr_s;
                acc_cnt <= acc_cnt + 16'h0001;
            end
        end
    end

    assign rsp_valid = (state_r == FULL);
    assign busy      = rsp_valid | (|req_valid);

endmodule

// File: tb/tb_gf8_mul_rr_sched.sv
// Scoreboard bench for gf8_mul_rr_sched: directed stimulus pushes hand-computed
// (id, product) pairs; a negedge monitor pops and compares on every delivered result.
module tb_gf8_mul_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_y;
    logic [1:0]  rsp_id;
    logic [15:0] acc_cnt;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] y;
    } exp_t;
    exp_t sb[$];

    gf8_mul_rr_sched #(.NREQ(4), .POLY(8'h1B), .IDW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_id(rsp_id),
        .acc_cnt(acc_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] y);
        exp_t e;
        e.id = id;
        e.y  = y;
        sb.push_back(e);
    endtask

    // Monitor: a result is consumed at the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            exp_t e;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rsp: got id=%0d y=%0h expected none", rsp_id, rsp_y);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_y} !== {e.id, e.y}) begin
                    fails++;
                    $display("FAIL rsp: got id=%0d y=%0h expected id=%0d y=%0h",
                             rsp_id, rsp_y, e.id, e.y);
                end
            end
        end
    end

    // Watchdog bounding the whole run.
    initial begin
        #5ms;
        $display("FAIL timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        req_a     = 32'h0000_0000;
        req_b     = 32'h0000_0000;
        step(); step();
        // reset state
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_y", {24'd0, rsp_y}, 32'h00);
        check("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        check("rst_acc_cnt", {16'd0, acc_cnt}, 32'd0);
        req_valid = 4'b1111;
        #1;
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        req_valid = 4'b0000;
        rst = 1'b0;
        step();

        // single multiply 0x57*0x83 = 0xC1
        req_a[7:0] = 8'h57; req_b[7:0] = 8'h83;
        req_valid = 4'b0001;
        #1;
        check("single_req_ready", {28'd0, req_ready}, 32'h1);
        push(2'd0, 8'hC1);
        step();
        req_valid = 4'b0000;
        check("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("single_acc_cnt", {16'd0, acc_cnt}, 32'd1);
        step();
        check("single_drain", {31'd0, rsp_valid}, 32'd0);

        // inverse, reduction, zero back-to-back from requester 0
        req_valid = 4'b0001;
        req_a[7:0] = 8'h53; req_b[7:0] = 8'hCA; push(2'd0, 8'h01); step();
        req_a[7:0] = 8'h02; req_b[7:0] = 8'h80; push(2'd0, 8'h1B); step();
        req_a[7:0] = 8'hFF; req_b[7:0] = 8'h00; push(2'd0, 8'h00); step();
        req_valid = 4'b0000;
        step();
        check("vec_acc_cnt", {16'd0, acc_cnt}, 32'd4);

        // round robin from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        check("rr_rst_acc", {16'd0, acc_cnt}, 32'd0);
        req_a = {8'hA5, 8'h02, 8'h53, 8'h57};
        req_b = {8'h01, 8'h80, 8'hCA, 8'h83};
        req_valid = 4'b1111;
        begin
            logic [1:0] ids [6];
            logic [7:0] ys  [4];
            ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            ys  = '{8'hC1, 8'h01, 8'h1B, 8'hA5};
            for (int n = 0; n < 6; n++) begin
                #1;
                check("rr_req_ready", {28'd0, req_ready}, 32'd1 << ids[n]);
                push(ids[n], ys[ids[n]]);
                step();
            end
        end
        req_valid = 4'b0000;
        step();
        check("rr_acc_cnt", {16'd0, acc_cnt}, 32'd6);

        // backpressure: pointer is at 2, so requester 2 wins first
        req_valid = 4'b1111;
        push(2'd2, 8'h1B);
        step();
        rsp_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("bp_req_ready", {28'd0, req_ready}, 32'd0);
            check("bp_rsp_y", {24'd0, rsp_y}, 32'h1B);
            check("bp_rsp_id", {30'd0, rsp_id}, 32'd2);
            check("bp_acc_cnt", {16'd0, acc_cnt}, 32'd7);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", {28'd0, req_ready}, 32'h8);
        push(2'd3, 8'hA5);
        step();
        req_valid = 4'b0000;
        step();
        check("bp_acc_cnt_after", {16'd0, acc_cnt}, 32'd8);

        // reset while a result is pending: it must be dropped
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        check("mid_pending", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_acc", {16'd0, acc_cnt}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        check("mid_first_grant", {28'd0, req_ready}, 32'h2);
        push(2'd1, 8'h01);
        step();
        req_valid = 4'b0000;
        step();

        // counter wrap after 65536 accepts
        rst = 1'b1; step(); rst = 1'b0;
        req_a[7:0] = 8'h02; req_b[7:0] = 8'h80;
        req_valid = 4'b0001;
        for (int n = 0; n < 65536; n++) begin
            if (n == 65535) begin
                check("wrap_pre", {16'd0, acc_cnt}, 32'hFFFF);
            end
            push(2'd0, 8'h1B);
            step();
        end
        req_valid = 4'b0000;
        check("wrap_zero", {16'd0, acc_cnt}, 32'h0000);
        req_a[7:0] = 8'hFF; req_b[7:0] = 8'h00;
        req_valid = 4'b0001;
        push(2'd0, 8'h00);
        step();
        req_valid = 4'b0000;
        step();
        check("wrap_post", {16'd0, acc_cnt}, 32'd1);
        check("final_valid", {31'd0, rsp_valid}, 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
